// File: rtl/param_dual_port_ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: depth helper,
// read-during-write mode encoding and read-port control states.
package ram_pkg;

    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

    function automatic int unsigned ram_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/param_dual_port_ram_if.sv
// Write/read port bundle of the dual-port RAM; master drives requests,
// slave (the RAM) returns registered read data and its valid strobe.
interface param_dual_port_ram_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/param_dual_port_ram_dec.sv
// N-to-2**N one-hot decoder with enable; drives the RAM word write selects.
module n_to_onehot_dec #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        x_in,
    input  logic                en,
    output logic [(2**N)-1:0]   y_out
);
    localparam int unsigned M = 32'd1 << N;

    always_comb begin
        y_out = '0;
        for (int unsigned i = 0; i < M; i++) begin
            y_out[i] = en && (x_in == N'(i));
        end
    end
endmodule

// File: rtl/param_dual_port_ram.sv
// Flop-array RAM with one write and one independent read port; registered
// read data with a one-cycle valid strobe and optional write-to-read bypass.
module param_dual_port_ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2,
    parameter bit          BYPASS = 1'b1
) (
    input logic clk,
    input logic rst,
    param_dual_port_ram_if.slave bus
);
    localparam int unsigned DEPTH    = ram_depth(ADDR_W);
    localparam rdw_mode_e   RDW_MODE = rdw_mode_e'(BYPASS);

    logic [DEPTH-1:0]             w_wr_sel;
    logic [DEPTH-1:0][DATA_W-1:0] w_words;
    logic [DATA_W-1:0]            w_mem_rd;
    logic                         w_rdw_hit;
    logic [DATA_W-1:0]            w_rd_next;
    logic [DATA_W-1:0]            r_rd_data;
    rd_state_e                    r_rd_state;
    rd_state_e                    w_rd_state_nxt;

    n_to_onehot_dec #(.N(ADDR_W)) u_wr_dec (
        .x_in  (bus.wr_addr),
        .en    (bus.wr_en),
        .y_out (w_wr_sel)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_word <= '0;
            end else if (w_wr_sel[g]) begin
                r_word <= bus.wr_data;
            end
        end

        assign w_words[g] = r_word;
    end

    // Bypass only when the collision mode asks for the freshly written word.
    assign w_mem_rd  = w_words[bus.rd_addr];
    assign w_rdw_hit = (RDW_MODE == RDW_NEW) && bus.wr_en && bus.rd_en &&
                       (bus.wr_addr == bus.rd_addr);
    assign w_rd_next = w_rdw_hit ? bus.wr_data : w_mem_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (bus.rd_en) begin
            r_rd_data <= w_rd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = RD_IDLE;
        if (bus.rd_en) begin
            w_rd_state_nxt = RD_VALID;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = (r_rd_state == RD_VALID);
endmodule

// File: tb/tb_param_dual_port_ram.sv
// Directed scoreboard bench: 4x4 RAM in both collision modes plus a 16x8 sweep.
module tb_param_dual_port_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_dual_port_ram_if #(.DATA_W(4), .ADDR_W(2)) ifa ();
    param_dual_port_ram_if #(.DATA_W(4), .ADDR_W(2)) ifb ();
    param_dual_port_ram_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

    assign ifb.wr_en   = ifa.wr_en;
    assign ifb.wr_addr = ifa.wr_addr;
    assign ifb.wr_data = ifa.wr_data;
    assign ifb.rd_en   = ifa.rd_en;
    assign ifb.rd_addr = ifa.rd_addr;

    param_dual_port_ram #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    param_dual_port_ram #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));
    param_dual_port_ram #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [3:0] mem_m [4];
    logic [3:0] qa [$];
    logic [3:0] qb [$];
    logic [7:0] qc [$];
    logic [3:0] last_a = '0;
    logic [3:0] last_b = '0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_state(input string tag);
        chk({tag, "_a_data"},  {4'h0, ifa.rd_data}, 8'h00);
        chk({tag, "_a_valid"}, {7'h0, ifa.rd_valid}, 8'h00);
        chk({tag, "_b_data"},  {4'h0, ifb.rd_data}, 8'h00);
        chk({tag, "_b_valid"}, {7'h0, ifb.rd_valid}, 8'h00);
        chk({tag, "_c_data"},  ifc.rd_data, 8'h00);
        chk({tag, "_c_valid"}, {7'h0, ifc.rd_valid}, 8'h00);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_m[i] = '0;
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
    endtask

    task automatic cycle(input bit we, input logic [1:0] wa, input logic [3:0] wd,
                         input bit re, input logic [1:0] ra, input string tag);
        logic [3:0] ea;
        logic [3:0] eb;
        ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd;
        ifa.rd_en = re; ifa.rd_addr = ra;
        if (re) begin
            qa.push_back((we && wa == ra) ? wd : mem_m[ra]);
            qb.push_back(mem_m[ra]);
        end
        if (we) mem_m[wa] = wd;
        @(posedge clk);
        #1;
        chk({tag, "_a_valid"}, {7'h0, ifa.rd_valid}, {7'h0, re});
        chk({tag, "_b_valid"}, {7'h0, ifb.rd_valid}, {7'h0, re});
        if (ifa.rd_valid) begin
            if (qa.size() == 0) begin
                chk({tag, "_a_noexp"}, 8'h01, 8'h00);
            end else begin
                ea = qa.pop_front();
                last_a = ea;
                chk({tag, "_a_data"}, {4'h0, ifa.rd_data}, {4'h0, ea});
            end
        end else begin
            chk({tag, "_a_hold"}, {4'h0, ifa.rd_data}, {4'h0, last_a});
        end
        if (ifb.rd_valid) begin
            if (qb.size() == 0) begin
                chk({tag, "_b_noexp"}, 8'h01, 8'h00);
            end else begin
                eb = qb.pop_front();
                last_b = eb;
                chk({tag, "_b_data"}, {4'h0, ifb.rd_data}, {4'h0, eb});
            end
        end else begin
            chk({tag, "_b_hold"}, {4'h0, ifb.rd_data}, {4'h0, last_b});
        end
    endtask

    task automatic cycle_c(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                           input bit re, input logic [3:0] ra, input logic [7:0] exp,
                           input string tag);
        logic [7:0] ec;
        ifc.wr_en = we; ifc.wr_addr = wa; ifc.wr_data = wd;
        ifc.rd_en = re; ifc.rd_addr = ra;
        if (re) qc.push_back(exp);
        @(posedge clk);
        #1;
        chk({tag, "_c_valid"}, {7'h0, ifc.rd_valid}, {7'h0, re});
        if (ifc.rd_valid && qc.size() != 0) begin
            ec = qc.pop_front();
            chk({tag, "_c_data"}, ifc.rd_data, ec);
        end
    endtask

    initial begin
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.rd_en = 1'b0; ifa.rd_addr = '0;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.rd_en = 1'b0; ifc.rd_addr = '0;
        model_reset();

        #2;
        chk_rst_state("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_rst_state("pulse");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'(i), "rd_reset");

        cycle(1'b1, 2'd0, 4'hA, 1'b0, 2'd0, "wr0");
        cycle(1'b1, 2'd1, 4'h5, 1'b0, 2'd0, "wr1");
        cycle(1'b1, 2'd2, 4'hC, 1'b0, 2'd0, "wr2");
        cycle(1'b1, 2'd3, 4'h3, 1'b0, 2'd0, "wr3");
        for (int i = 3; i >= 0; i--) cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'(i), "rd_back");

        cycle(1'b1, 2'd2, 4'h1, 1'b0, 2'd0, "wr2_1");
        cycle(1'b1, 2'd2, 4'hF, 1'b1, 2'd2, "rdw_collide");
        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, "rdw_after");

        cycle(1'b1, 2'd1, 4'h7, 1'b1, 2'd3, "indep");
        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, "indep_rd1");
        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd0, "indep_rd0");
        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd2, "indep_rd2");
        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd3, "indep_rd3");

        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd0, "hold_rd");
        cycle(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, "hold_idle");
        cycle(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, "hold_idle2");

        cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, "pre_rst_rd");
        ifa.rd_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_rst_state("mid_rst");
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 4'h0, 1'b1, 2'(i), "rd_cleared");
        cycle(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, "a_idle");

        for (int i = 0; i < 16; i++)
            cycle_c(1'b1, 4'(i), 8'h10 + 8'(i), 1'b0, 4'd0, 8'h00, "sweep_wr");
        for (int i = 0; i < 16; i++)
            cycle_c(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 8'h10 + 8'(i), "sweep_rd");
        cycle_c(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, "sweep_idle");
        chk("sweep_c_data_hold", ifc.rd_data, 8'h1F);
        chk("sweep_c_queue_empty", 8'(qc.size()), 8'h00);
        chk("a_queue_empty", 8'(qa.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule

// File: doc/param_dual_port_ram.md
Name: param_dual_port_ram

Overview:
- Parametrised, clocked successor to the team's small 4x4 decoder-plus-cell RAM.
- Has one write port and one independent read port, so a write and a read can be issued in the same cycle.
- Read data is registered and comes with a valid strobe; an optional bypass forwards write data when a read hits the word being written.
- Used as a register-file / scratch store inside datapath blocks; storage is a flop array, so reset clears every word.

Parameters:
- DATA_W, 4, word width in bits (>=1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
- BYPASS, 1, 1 = read-during-write to the same address returns new data; 0 = returns old data

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request for this cycle
- wr_addr  input  ADDR_W  write word address
- wr_data  input  DATA_W  write data
- rd_en  input  1  read request for this cycle
- rd_addr  input  ADDR_W  read word address
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  high for exactly one cycle, the cycle after an accepted read

Behaviour:
- Reset (asynchronous, active-high):
  - On rst assertion, all DEPTH words become 0, rd_data becomes 0 and rd_valid becomes 0, immediately and without waiting for clk.
  - While rst is high, wr_en and rd_en are ignored.
  - First accepted operation is on the first rising edge after rst deasserts.
- Write:
  - On a rising edge with wr_en=1, mem[wr_addr] <= wr_data.
  - Only the addressed word changes; all other words hold.
  - Write address decode goes through the one-hot decoder; exactly one word select is active when wr_en=1, none when wr_en=0.
- Read:
  - On a rising edge with rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1.
  - Latency is 1 clock.
  - On a rising edge with rd_en=0, rd_valid <= 0 and rd_data holds its last value. It does not go to 0 and is never driven Z.
- Read-during-write (wr_en=1, rd_en=1, wr_addr==rd_addr, same edge):
  - BYPASS=1: rd_data <= wr_data.
  - BYPASS=0: rd_data <= the word's pre-write contents.
  - The write is performed in both cases.
- Different addresses on the same edge: the two operations are fully independent.
- Back-to-back reads: one read may be accepted every cycle. rd_valid stays high continuously and rd_data updates every cycle.
- Reset mid-operation: a read accepted on the edge before rst is asserted has its rd_valid cleared by rst. Its data is lost; no retry is made.
- Widths:
  - Addresses are full range 0..DEPTH-1; no out-of-range case exists.
  - No width conversion; data passes through bit-exact.
- State machine:
  - Per-port 2-state read control, IDLE -> VALID on rd_en, and VALID -> IDLE on !rd_en.
  - This is encoded as the rd_valid flop itself.

Decomposition:
- Shared package `ram_pkg` holds:
  - localparam helper DEPTH(ADDR_W) = 1 << ADDR_W
  - an enum for the BYPASS modes, RDW_NEW=1 and RDW_OLD=0
- Sub-module `n_to_onehot_dec`:
  - Parameter N.
  - Inputs x_in[N-1:0] and en; output y_out[2**N-1:0].
  - y_out[i] = en && (x_in == i).
  - Generalises the existing 2-to-4 decoder and drives the write word selects.
- Storage is a generate loop of DATA_W-wide words.
- The read mux and bypass compare live in the top module.

Test Plan:
- Reset then read:
  - Pulse rst asynchronously between edges. rd_data=0 and rd_valid=0 immediately.
  - Then read addrs 0..3 on consecutive cycles: rd_data=4'h0 each, rd_valid high for 4 cycles.
- Write then read:
  - Write 0->4'hA, 1->4'h5, 2->4'hC, 3->4'h3, then read 3,2,1,0.
  - Required: rd_data 4'h3, 4'hC, 4'h5, 4'hA, each one cycle after its request.
- Same-address collision:
  - With mem[2]=4'h1, issue wr 2<-4'hF and rd 2 on the same edge.
  - BYPASS=1 gives rd_data=4'hF; BYPASS=0 gives rd_data=4'h1.
  - A following read of 2 gives 4'hF in both modes.
- Concurrent independent ports:
  - Write 1<-4'h7 while reading 3 (=4'h3): rd_data=4'h3.
  - A next-cycle read of 1 gives 4'h7, and words 0, 2 and 3 are unchanged.
- Idle hold and reset mid-read:
  - After reading 4'hA, deassert rd_en: rd_valid drops to 0 and rd_data stays 4'hA.
  - Assert rst during a valid cycle: rd_valid=0 and rd_data=0 at once, and all words read back 0.
- Parameter sweep: DATA_W=8, ADDR_W=4. Write word i <- 8'h10+i for all 16 words, then read all back exactly, with no aliasing.
